// File: rtl/hazard_stall_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_stall_scoreboard
//
// Tracks the register write intent (provide mask) of every instruction that
// has left ID and is still in flight in the DEPTH back-end stages
// (stage 0 = OF ... stage DEPTH-1 = WB). ID is stalled when the instruction
// it holds reads or writes a register that an older in-flight instruction
// will still write (RAW / WAW). A stalled cycle pushes a bubble into stage 0.
// A freeze from the back end, a branch flush, an optional last-stage bypass
// and a saturating stall-cycle counter are included.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         synchronous, active-high; clears all tracking and stall_cnt
//   id_valid      ID holds a valid decoded instruction
//   id_req        registers read by the ID instruction
//   id_prov       registers written by the ID instruction
//   hold          back-end freeze; every tracked stage keeps its contents
//   flush         redirect; kills the ID instruction and stages 0..DEPTH-2
//                 (the oldest instruction still retires on that edge)
//   id_stall      ID must keep its instruction this cycle
//   id_accept     ID instruction enters stage 0 at this edge
//   pend_mask     OR of provide masks of all valid tracked stages
//   retire_valid  the stage DEPTH-1 instruction leaves the pipe at this edge
//   retire_prov   provide mask of the retiring instruction (0 otherwise)
//   stall_cnt     saturating count of stalled ID cycles
//
// Parameters
//   NUM_REGS   architectural register count (mask width)
//   DEPTH      tracked stages after ID, legal range 2..8
//   BYPASS_EN  1 = the last stage forwards its result, so it never conflicts
//   CNT_W      width of stall_cnt
// ---------------------------------------------------------------------------
module hazard_stall_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int DEPTH     = 3,
  parameter int BYPASS_EN = 0,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [NUM_REGS-1:0] id_req,
  input  logic [NUM_REGS-1:0] id_prov,
  input  logic                hold,
  input  logic                flush,
  output logic                id_stall,
  output logic                id_accept,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic                retire_valid,
  output logic [NUM_REGS-1:0] retire_prov,
  output logic [CNT_W-1:0]    stall_cnt
);

  // Highest stage index that participates in the conflict check. With the
  // bypass enabled the WB stage result is forwarded and is left out.
  localparam int EFF_LAST = (BYPASS_EN != 0) ? DEPTH - 2 : DEPTH - 1;

  // Per-stage tracking. A bubble always carries an all-zero provide mask, so
  // the masks can be ORed without qualifying them with the valid bits.
  logic                vld_p  [DEPTH];
  logic [NUM_REGS-1:0] prov_p [DEPTH];

  logic [NUM_REGS-1:0] pend_all;
  logic [NUM_REGS-1:0] pend_eff;
  logic                conflict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    if (&x) begin
      return x;
    end
    return x + one;
  endfunction

  // ID stage: hazard detection against the older in-flight instructions only.
  always_comb begin
    pend_all = '0;
    pend_eff = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pend_all = pend_all | prov_p[k];
      if (k <= EFF_LAST) begin
        pend_eff = pend_eff | prov_p[k];
      end
    end
  end

  always_comb begin
    conflict     = id_valid & (|((id_req | id_prov) & pend_eff));
    id_stall     = id_valid & (conflict | hold);
    // Reset gating keeps a dropped pipe from reporting accepts or retires.
    id_accept    = id_valid & ~id_stall & ~flush & ~reset;
    // A flush drains the oldest instruction even while the back end is frozen.
    retire_valid = vld_p[DEPTH-1] & (~hold | flush) & ~reset;
    retire_prov  = retire_valid ? prov_p[DEPTH-1] : '0;
    pend_mask    = pend_all;
  end

  // Stage 0..DEPTH-1: shift register of valid bits and provide masks.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_p[k]  <= 1'b0;
        prov_p[k] <= '0;
      end
    end else if (!hold) begin
      vld_p[0]  <= id_accept;
      prov_p[0] <= id_accept ? id_prov : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_p[k]  <= vld_p[k-1];
        prov_p[k] <= prov_p[k-1];
      end
    end
  end

  // Stall statistics: a flushed ID instruction is discarded, not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (id_stall && !flush) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
